// File: rtl/tqvp_htfab_vga_capture.sv
// VGA thumbnail grabber: samples a 32x16 monochrome image from a pixel/hsync/vsync
// stream into a register buffer readable over the peripheral bus.
module tqvp_htfab_vga_capture #(
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VS, ST_CAPTURE} state_t;

    localparam logic [31:0] CFG_RST = {6'd30, 10'd33, 8'd50, 8'd122};

    state_t             state_q, state_d;
    logic [31:0]        cfg_q;
    logic [2:0]         ui_q;
    logic [15:0][31:0]  buf_q;
    logic [9:0]         line_cnt_q, line_cnt_d;
    logic [10:0]        target_q, target_d;
    logic [3:0]         row_q, row_d;
    logic               samp_q, samp_d;
    logic [5:0]         smp_n_q, smp_n_d;
    logic [7:0]         tmr_q, tmr_d;
    logic [31:0]        shift_q, shift_d;
    logic               store_q, store_d;
    logic               cont_q, cont_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [31:0]        data_out_q;
    logic               data_ready_q;

    logic               wr_en;
    logic [3:0]         wr_row;
    logic [31:0]        wr_data;
    logic               frame_start, frame_end;
    logic [9:0]         cnt_next;
    logic [10:0]        tgt_eff;

    logic [7:0]         h_start, pix_div;
    logic [9:0]         v_start;
    logic [5:0]         v_step;
    assign h_start = cfg_q[7:0];
    assign pix_div = cfg_q[15:8];
    assign v_start = cfg_q[25:16];
    assign v_step  = (cfg_q[31:26] == 6'd0) ? 6'd1 : cfg_q[31:26];

    // Edges compare the live input against the single registered copy.
    logic hs_act, vs_act, hs_act_q, vs_act_q, hs_edge, vs_edge, pix_bit;
    assign hs_act   = (ui_in[1] == SYNC_POL);
    assign vs_act   = (ui_in[2] == SYNC_POL);
    assign hs_act_q = (ui_q[1] == SYNC_POL);
    assign vs_act_q = (ui_q[2] == SYNC_POL);
    assign hs_edge  = hs_act_q & ~hs_act;
    assign vs_edge  = vs_act_q & ~vs_act;
    assign pix_bit  = ui_q[0] & ~hs_act_q & ~vs_act_q;

    logic wr_cfg, wr_cmd, rd_req, rd_word;
    logic cmd_arm_s, cmd_arm_c, cmd_abort, cmd_clr;
    assign wr_cfg    = (data_write_n == 2'b10);
    assign wr_cmd    = (data_write_n == 2'b00);
    assign rd_req    = (data_read_n != 2'b11);
    assign rd_word   = (data_read_n == 2'b10);
    assign cmd_arm_s = wr_cmd & data_in[0];
    assign cmd_arm_c = wr_cmd & data_in[1];
    assign cmd_abort = wr_cmd & data_in[2];
    assign cmd_clr   = wr_cmd & data_in[3];

    logic [31:0] status;
    assign status = {28'd0, err_q, done_q, (state_q != ST_IDLE), cont_q};

    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        target_d    = target_q;
        row_d       = row_q;
        samp_d      = samp_q;
        smp_n_d     = smp_n_q;
        tmr_d       = tmr_q;
        shift_d     = shift_q;
        store_d     = 1'b0;
        cont_d      = cont_q;
        done_d      = done_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        wr_row      = row_q;
        wr_data     = '0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        cnt_next    = line_cnt_q;
        tgt_eff     = target_q;

        if (cmd_clr) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_arm_s || cmd_arm_c) begin
                    state_d = ST_WAIT_VS;
                    cont_d  = cmd_arm_c;
                end
            end
            ST_WAIT_VS: begin
                if (!cmd_abort && vs_edge) begin
                    state_d     = ST_CAPTURE;
                    frame_start = 1'b1;
                end
            end
            ST_CAPTURE: if (!cmd_abort) begin
                // A new line cutting a row short takes priority over its next sample.
                if (hs_edge && samp_q) begin
                    samp_d = 1'b0;
                end else if (samp_q) begin
                    if (tmr_q == 8'd0) begin
                        shift_d = {pix_bit, shift_q[31:1]};
                        smp_n_d = smp_n_q + 6'd1;
                        tmr_d   = pix_div;
                        if (smp_n_q == 6'd31) begin
                            samp_d  = 1'b0;
                            store_d = 1'b1;
                        end
                    end else begin
                        tmr_d = tmr_q - 8'd1;
                    end
                end

                if (store_q || (hs_edge && samp_q)) begin
                    wr_en    = 1'b1;
                    wr_data  = store_q ? shift_q : (shift_q >> (6'd32 - smp_n_q));
                    row_d    = row_q + 4'd1;
                    tgt_eff  = target_q + {5'd0, v_step};
                    target_d = tgt_eff;
                    if (row_q == 4'd15) begin
                        frame_end = 1'b1;
                        done_d    = 1'b1;
                        samp_d    = 1'b0;
                        state_d   = cont_q ? ST_WAIT_VS : ST_IDLE;
                    end
                end

                if (!frame_end) begin
                    if (vs_edge) begin
                        err_d = 1'b1;
                        if (cont_q) begin
                            frame_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            samp_d  = 1'b0;
                        end
                    end else if (hs_edge) begin
                        cnt_next   = (line_cnt_q == 10'h3FF) ? line_cnt_q : line_cnt_q + 10'd1;
                        line_cnt_d = cnt_next;
                        if ({1'b0, cnt_next} == tgt_eff) begin
                            samp_d  = 1'b1;
                            smp_n_d = 6'd0;
                            tmr_d   = h_start;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line 0 starts at the vsync release itself.
        if (frame_start) begin
            line_cnt_d = 10'd0;
            row_d      = 4'd0;
            target_d   = {1'b0, v_start};
            samp_d     = (v_start == 10'd0);
            smp_n_d    = 6'd0;
            tmr_d      = h_start;
            store_d    = 1'b0;
        end

        if (cmd_abort) begin
            state_d = ST_IDLE;
            samp_d  = 1'b0;
            store_d = 1'b0;
            cont_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ui_q       <= {~SYNC_POL, ~SYNC_POL, 1'b0};
            line_cnt_q <= '0;
            target_q   <= '0;
            row_q      <= '0;
            samp_q     <= 1'b0;
            smp_n_q    <= '0;
            tmr_q      <= '0;
            shift_q    <= '0;
            store_q    <= 1'b0;
            cont_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ui_q       <= ui_in[2:0];
            line_cnt_q <= line_cnt_d;
            target_q   <= target_d;
            row_q      <= row_d;
            samp_q     <= samp_d;
            smp_n_q    <= smp_n_d;
            tmr_q      <= tmr_d;
            shift_q    <= shift_d;
            store_q    <= store_d;
            cont_q     <= cont_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= CFG_RST;
        end else if (wr_cfg) begin
            cfg_q <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (wr_en) begin
            buf_q[wr_row] <= wr_data;
        end
    end

    // Read data is taken before this cycle's store lands, so a colliding read sees the old row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
        end else begin
            data_ready_q <= rd_req;
            if (rd_req) begin
                data_out_q <= rd_word ? buf_q[address[5:2]] : status;
            end
        end
    end

    assign data_out       = data_out_q;
    assign data_ready     = data_ready_q;
    assign user_interrupt = done_q;
    assign uo_out         = 8'd0;

    logic unused_ok;
    assign unused_ok = &{1'b0, ui_in[7:3], address[1:0]};

endmodule

// File: tb/tb_tqvp_htfab_vga_capture.sv
// Directed bench for the VGA capture block: short synthetic frames, register reads.
module tb_tqvp_htfab_vga_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ui_in, uo_out;
    logic [5:0]  address;
    logic [31:0] data_in, data_out;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_ready, user_interrupt;
    logic        hs, vs, pix;
    int          total = 0;
    int          bad = 0;
    int          hst, pdv;

    assign ui_in = {5'b0, vs, hs, pix};
    always #8 clk = ~clk;

    tqvp_htfab_vga_capture #(.SYNC_POL(1'b0)) dut (
        .clk            (clk),
        .rst            (rst),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sz, input logic [31:0] d);
        data_write_n = sz;
        data_in      = d;
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [1:0] sz, input logic [5:0] a, input string tag,
                      input logic [31:0] exp);
        data_read_n = sz;
        address     = a;
        tick();
        data_read_n = 2'b11;
        check({tag, "/rdy"}, 32'(data_ready), 32'd1);
        check(tag, data_out, exp);
        tick();
    endtask

    // hsync pulse of hl cycles, then al cycles of active video; vsync releases with hsync.
    task automatic run_line(input int hl, input int al, input int mode);
        hs  = 1'b0;
        pix = 1'b0;
        repeat (hl) tick();
        for (int j = 0; j < al; j++) begin
            hs = 1'b1;
            vs = 1'b1;
            case (mode)
                1:       pix = (j >= hst) && ((((j - hst) / (pdv + 1)) % 2) == 0);
                2:       pix = (j == hst);
                3:       pix = 1'b1;
                default: pix = 1'b0;
            endcase
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1; pix = 1'b0;
        address = '0; data_in = '0; data_write_n = 2'b11; data_read_n = 2'b11;
        hst = 4; pdv = 0;
        repeat (3) tick();
        check("rst_dout", data_out, 32'd0);
        check("rst_rdy", 32'(data_ready), 32'd0);
        check("rst_irq", 32'(user_interrupt), 32'd0);
        check("rst_uo", 32'(uo_out), 32'd0);
        rst = 1'b0;
        tick();
        rd(2'b00, 6'd0, "st_rst", 32'h0);
        rd(2'b10, 6'd0, "row0_rst", 32'h0);
        wr(2'b01, 32'h1);
        rd(2'b01, 6'd0, "st_wr16", 32'h0);

        // Reset CFG: row 0 on line 33, first sample 122 cycles in, every 51 cycles.
        hst = 122; pdv = 50;
        wr(2'b00, 32'h1);
        rd(2'b00, 6'd0, "st_arm", 32'h2);
        vs = 1'b0;
        repeat (33) run_line(2, 20, 0);
        run_line(2, 1710, 1);
        wr(2'b00, 32'h4);
        rd(2'b00, 6'd0, "st_abort", 32'h0);
        rd(2'b10, 6'd0, "dflt_row0", 32'h55555555);
        rd(2'b10, 6'd4, "dflt_row1", 32'h0);

        // Scaled full frame, alternating columns, rows every 2 lines from line 2.
        hst = 2; pdv = 1;
        wr(2'b10, {6'd2, 10'd2, 8'd1, 8'd2});
        wr(2'b00, 32'h1);
        vs = 1'b0;
        repeat (33) run_line(2, 70, 1);
        tick();
        rd(2'b00, 6'd0, "st_frame", 32'h4);
        check("irq_frame", 32'(user_interrupt), 32'd1);
        for (int r = 0; r < 16; r++) rd(2'b10, 6'(r * 4), $sformatf("alt_row%0d", r), 32'h55555555);

        // Every line, first sample only lit.
        wr(2'b00, 32'h8);
        check("irq_clr", 32'(user_interrupt), 32'd0);
        rd(2'b00, 6'd0, "st_clr", 32'h0);
        hst = 4; pdv = 0;
        wr(2'b10, {6'd1, 10'd0, 8'd0, 8'd4});
        wr(2'b00, 32'h1);
        vs = 1'b0;
        repeat (16) run_line(2, 40, 2);
        tick();
        rd(2'b00, 6'd0, "st_first", 32'h4);
        for (int r = 0; r < 16; r++) rd(2'b10, 6'(r * 4), $sformatf("first_row%0d", r), 32'h1);

        // Line cut short after 10 lit samples; next line still captured.
        wr(2'b00, 32'h8);
        wr(2'b00, 32'h1);
        vs = 1'b0;
        run_line(2, 14, 3);
        run_line(2, 40, 0);
        wr(2'b00, 32'h4);
        rd(2'b10, 6'd0, "short_row0", 32'h000003FF);
        rd(2'b10, 6'd4, "short_row1", 32'h0);
        rd(2'b10, 6'd8, "short_row2", 32'h1);

        // Vsync after 5 rows: error, single mode drops to idle.
        wr(2'b00, 32'h1);
        vs = 1'b0;
        repeat (5) run_line(2, 40, 3);
        vs = 1'b0;
        run_line(2, 4, 0);
        tick();
        rd(2'b00, 6'd0, "st_err", 32'h8);
        check("irq_err", 32'(user_interrupt), 32'd0);
        for (int r = 0; r < 5; r++) rd(2'b10, 6'(r * 4), $sformatf("err_row%0d", r), 32'hFFFFFFFF);
        rd(2'b10, 6'd20, "err_row5", 32'h1);
        rd(2'b10, 6'd60, "err_row15", 32'h1);

        // Continuous: two frames, interrupt cleared in between.
        wr(2'b00, 32'h8);
        rd(2'b00, 6'd0, "st_clr2", 32'h0);
        wr(2'b00, 32'h2);
        rd(2'b00, 6'd0, "st_cont", 32'h3);
        wr(2'b00, 32'h1);
        rd(2'b00, 6'd0, "st_rearm", 32'h3);
        vs = 1'b0;
        repeat (16) run_line(2, 40, 2);
        tick();
        check("irq_c1", 32'(user_interrupt), 32'd1);
        rd(2'b00, 6'd0, "st_c1", 32'h7);
        wr(2'b00, 32'h8);
        check("irq_c1_clr", 32'(user_interrupt), 32'd0);
        rd(2'b00, 6'd0, "st_c1_clr", 32'h3);
        vs = 1'b0;
        repeat (16) run_line(2, 40, 0);
        tick();
        check("irq_c2", 32'(user_interrupt), 32'd1);
        rd(2'b10, 6'd28, "c2_row7", 32'h0);
        wr(2'b00, 32'h8);
        wr(2'b00, 32'h6);
        rd(2'b00, 6'd0, "st_abort_arm", 32'h0);

        // Reset in the middle of a captured line.
        wr(2'b00, 32'h1);
        rd(2'b00, 6'd0, "st_arm2", 32'h2);
        vs = 1'b0;
        run_line(2, 40, 3);
        run_line(2, 40, 3);
        run_line(2, 20, 3);
        rst = 1'b1;
        tick();
        check("mid_dout", data_out, 32'd0);
        check("mid_rdy", 32'(data_ready), 32'd0);
        check("mid_irq", 32'(user_interrupt), 32'd0);
        check("mid_uo", 32'(uo_out), 32'd0);
        rst = 1'b0;
        tick();
        rd(2'b00, 6'd0, "st_mid", 32'h0);
        data_read_n = 2'b10;
        address     = 6'd0;
        tick();
        data_read_n = 2'b11;
        check("mid_row0_rdy", 32'(data_ready), 32'd1);
        check("mid_row0", data_out, 32'd0);
        tick();
        check("mid_row0_rdy_low", 32'(data_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
